// File: rtl/int_alu_slave.sv
// int_alu_slave: memory-mapped integer ALU on the shared 256-bit data bus.
//
// The engine writes operands S1 (0x?000) and S2 (0x?001), then reads one
// result word whose address[11:8] selects the operation. Results are
// combinational from the operand registers; sticky status flags and the
// operand-write counter are registered.
//
// Ports:
//   clk      in     bus clock, all state updates on posedge
//   reset    in     synchronous, active-high
//   address  in     16-bit bus address; only [15:12] is region-decoded
//   nRead    in     active-low read strobe
//   nWrite   in     active-low write strobe
//   dataBus  inout  256-bit shared bus, driven only on a decoded read
//
// Build option: define INT_ALU_MULDIV_EN to implement MUL/DIV/MOD
// (idx 3/4/5). Without it those reads return 0 and set ILL, and no
// multiplier or divider is built.

module int_alu_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h3000,
    parameter int unsigned OP_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        nRead,
    input  logic        nWrite,
    inout  wire  [255:0] dataBus
);

    localparam int unsigned DATA_W = 256;
    localparam int unsigned EXT_W  = DATA_W - OP_W;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MSB    = OP_W - 1;

    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [CNT_W-1:0]  r_op_count;
    logic              r_ovf;
    logic              r_dz;
    logic              r_ill;

    // Bus decode
    logic       w_hit;
    logic [3:0] w_idx;
    logic       w_rd;
    logic       w_wr;
    logic       w_conf;
    logic       w_drive;

    assign w_hit   = (address[15:12] == BASE_ADDR[15:12]);
    assign w_idx   = address[11:8];
    assign w_rd    = w_hit && !nRead && nWrite;
    assign w_wr    = w_hit && !nWrite && nRead;
    assign w_conf  = w_hit && !nRead && !nWrite;
    assign w_drive = w_rd && !reset;

    // Arithmetic datapath on the low OP_W bits
    logic signed [OP_W-1:0] w_s1;
    logic signed [OP_W-1:0] w_s2;
    logic        [OP_W-1:0] w_sum;
    logic        [OP_W-1:0] w_diff;
    logic                   w_add_ovf;
    logic                   w_sub_ovf;
    logic                   w_eq;
    logic                   w_lt;

    assign w_s1      = r_s1[OP_W-1:0];
    assign w_s2      = r_s2[OP_W-1:0];
    assign w_sum     = w_s1 + w_s2;
    assign w_diff    = w_s1 - w_s2;
    // Signed overflow: operand signs imply a result sign that did not appear
    assign w_add_ovf = (w_s1[MSB] == w_s2[MSB]) && (w_sum[MSB]  != w_s1[MSB]);
    assign w_sub_ovf = (w_s1[MSB] != w_s2[MSB]) && (w_diff[MSB] != w_s1[MSB]);
    assign w_eq      = (w_s1 == w_s2);
    assign w_lt      = (w_s1 < w_s2);

`ifdef INT_ALU_MULDIV_EN
    logic                   w_s2_zero;
    logic signed [OP_W-1:0] w_divisor;
    logic        [OP_W-1:0] w_mul;
    logic signed [OP_W-1:0] w_div;
    logic signed [OP_W-1:0] w_mod;

    assign w_s2_zero = (w_s2 == '0);
    // Substitute 1 for a zero divisor so the divider never sees 0
    assign w_divisor = w_s2_zero ? OP_W'(1) : w_s2;
    assign w_mul     = w_s1 * w_s2;
    assign w_div     = w_s1 / w_divisor;
    assign w_mod     = w_s1 % w_divisor;
`endif

    function automatic logic [DATA_W-1:0] f_sext(input logic [OP_W-1:0] v);
        return {{EXT_W{v[OP_W-1]}}, v};
    endfunction

    // Result mux and flag-set conditions for the current read
    logic [DATA_W-1:0] w_rdata;
    logic              w_set_ovf;
    logic              w_set_dz;
    logic              w_set_ill;

    always_comb begin
        w_rdata   = '0;
        w_set_ovf = 1'b0;
        w_set_dz  = 1'b0;
        w_set_ill = 1'b0;
        case (w_idx)
            4'd0: begin
                if (address[7:0] == 8'h00) begin
                    w_rdata = r_s1;
                end else if (address[7:0] == 8'h01) begin
                    w_rdata = r_s2;
                end
            end
            4'd1: begin
                w_rdata   = f_sext(w_sum);
                w_set_ovf = w_add_ovf;
            end
            4'd2: begin
                w_rdata   = f_sext(w_diff);
                w_set_ovf = w_sub_ovf;
            end
`ifdef INT_ALU_MULDIV_EN
            4'd3: w_rdata = f_sext(w_mul);
            4'd4: begin
                if (w_s2_zero) begin
                    w_rdata  = '1;
                    w_set_dz = 1'b1;
                end else begin
                    w_rdata = f_sext(w_div);
                end
            end
            4'd5: begin
                if (w_s2_zero) begin
                    w_rdata  = f_sext(w_s1);
                    w_set_dz = 1'b1;
                end else begin
                    w_rdata = f_sext(w_mod);
                end
            end
`else
            4'd3, 4'd4, 4'd5: w_set_ill = 1'b1;
`endif
            4'd6:  w_rdata = f_sext(w_s1 & w_s2);
            4'd7:  w_rdata = f_sext(w_s1 | w_s2);
            4'd8:  w_rdata = f_sext(w_s1 ^ w_s2);
            4'd9:  w_set_ill = 1'b1;
            4'd10: w_rdata = DATA_W'(w_eq);
            4'd11: w_rdata = DATA_W'(!w_eq);
            4'd12: w_rdata = DATA_W'(w_lt);
            4'd13: w_rdata = DATA_W'(!w_lt && !w_eq);
            4'd14: w_rdata = DATA_W'(w_lt || w_eq);
            4'd15: begin
                w_rdata[2:0]   = {r_ill, r_dz, r_ovf};
                w_rdata[47:32] = r_op_count;
            end
            default: w_rdata = '0;
        endcase
    end

    assign dataBus = w_drive ? w_rdata : {DATA_W{1'bz}};

    // Operand registers and operand-write counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_op_count <= '0;
        end else if (w_wr) begin
            if (address[11:0] == 12'h000) begin
                r_s1 <= dataBus;
            end else if (address[11:0] == 12'h001) begin
                r_s2       <= dataBus;
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    // Sticky status flags; clear via write to 0x?F00
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
            r_ill <= 1'b0;
        end else if (w_wr && (address[11:0] == 12'hF00)) begin
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
            r_ill <= 1'b0;
        end else if (w_rd) begin
            r_ovf <= r_ovf | w_set_ovf;
            r_dz  <= r_dz  | w_set_dz;
            r_ill <= r_ill | w_set_ill;
        end else if (w_conf) begin
            r_ill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_int_alu_slave.sv
// Directed self-checking bench for int_alu_slave (OP_W = 32).
// Expectations for MUL/DIV/MOD follow INT_ALU_MULDIV_EN.

module tb_int_alu_slave;

    logic         clk;
    logic         reset;
    logic [15:0]  address;
    logic         nRead;
    logic         nWrite;
    logic         tb_en;
    logic [255:0] tb_data;
    wire  [255:0] dataBus;

    int total;
    int bad;
    int exp_cnt;

    assign dataBus = tb_en ? tb_data : {256{1'bz}};

    int_alu_slave #(
        .BASE_ADDR (16'h3000),
        .OP_W      (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .nRead   (nRead),
        .nWrite  (nWrite),
        .dataBus (dataBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] sx(input logic [31:0] v);
        return {{224{v[31]}}, v};
    endfunction

    function automatic logic [255:0] st(input int cnt, input logic [2:0] flags);
        logic [255:0] s;
        s = '0;
        s[47:32] = 16'(cnt);
        s[2:0] = flags;
        return s;
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [255:0] d);
        @(negedge clk);
        address = a; nWrite = 1'b0; nRead = 1'b1; tb_en = 1'b1; tb_data = d;
        @(posedge clk);
        #1;
        nWrite = 1'b1; tb_en = 1'b0; address = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [255:0] d);
        @(negedge clk);
        address = a; nRead = 1'b0; nWrite = 1'b1; tb_en = 1'b0;
        #1 d = dataBus;
        @(posedge clk);
        #1;
        nRead = 1'b1; address = 16'h0000;
    endtask

    task automatic test_reset();
        logic [255:0] got;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        // A read during reset must not be driven; bench drives 0 to detect contention
        @(negedge clk);
        address = 16'h3A00; nRead = 1'b0; tb_en = 1'b1; tb_data = '0;
        #1 got = dataBus;
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL reset_drive got=%h exp=%h", got, 256'd0);
        end
        @(posedge clk); #1;
        nRead = 1'b1; tb_en = 1'b0; address = 16'h0000;
        repeat (5) bus_write(16'h3000, 256'd5);
        @(negedge clk);
        reset = 1'b0;
        bus_read(16'h3F00, got);
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL reset_status got=%h exp=%h", got, 256'd0);
        end
        bus_read(16'h3000, got);
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL reset_s1 got=%h exp=%h", got, 256'd0);
        end
    endtask

    task automatic test_arith();
        logic [15:0]  addr_tab [0:14];
        logic [255:0] exp_tab  [0:14];
        logic [255:0] got;
        logic [255:0] exp;
        bus_write(16'h3000, sx(32'd7));
        bus_write(16'h3001, sx(32'hFFFF_FFFD));
        exp_cnt = 1;
        addr_tab = '{16'h3000, 16'h3001, 16'h3100, 16'h3200, 16'h3300,
                     16'h3400, 16'h3500, 16'h3600, 16'h3700, 16'h3800,
                     16'h3A00, 16'h3B00, 16'h3C00, 16'h3D00, 16'h3E00};
`ifdef INT_ALU_MULDIV_EN
        exp_tab = '{sx(32'd7), sx(32'hFFFF_FFFD), sx(32'd4), sx(32'd10), sx(32'hFFFF_FFEB),
                    sx(32'hFFFF_FFFE), sx(32'd1), sx(32'd5), sx(32'hFFFF_FFFF), sx(32'hFFFF_FFFA),
                    256'd0, 256'd1, 256'd0, 256'd1, 256'd0};
`else
        exp_tab = '{sx(32'd7), sx(32'hFFFF_FFFD), sx(32'd4), sx(32'd10), 256'd0,
                    256'd0, 256'd0, sx(32'd5), sx(32'hFFFF_FFFF), sx(32'hFFFF_FFFA),
                    256'd0, 256'd1, 256'd0, 256'd1, 256'd0};
`endif
        for (int i = 0; i < 15; i++) begin
            bus_read(addr_tab[i], got);
            total++;
            if (got !== exp_tab[i]) begin
                bad++; $display("FAIL arith_%h got=%h exp=%h", addr_tab[i], got, exp_tab[i]);
            end
        end
`ifdef INT_ALU_MULDIV_EN
        exp = st(exp_cnt, 3'b000);
`else
        exp = st(exp_cnt, 3'b100);
`endif
        bus_read(16'h3F00, got);
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL arith_status got=%h exp=%h", got, exp);
        end
        bus_write(16'h3F00, '1);
    endtask

    task automatic test_overflow();
        logic [255:0] got;
        bus_write(16'h3000, {224'd0, 32'h7FFF_FFFF});
        bus_write(16'h3001, sx(32'd1));
        exp_cnt = 2;
        bus_read(16'h3100, got);
        total++;
        if (got !== sx(32'h8000_0000)) begin
            bad++; $display("FAIL add_ovf_value got=%h exp=%h", got, sx(32'h8000_0000));
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(exp_cnt, 3'b001)) begin
            bad++; $display("FAIL add_ovf_flag got=%h exp=%h", got, st(exp_cnt, 3'b001));
        end
        bus_write(16'h3F00, 256'd0);
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(exp_cnt, 3'b000)) begin
            bad++; $display("FAIL flag_clear got=%h exp=%h", got, st(exp_cnt, 3'b000));
        end
        bus_write(16'h3000, sx(32'h8000_0000));
        bus_read(16'h3200, got);
        total++;
        if (got !== sx(32'h7FFF_FFFF)) begin
            bad++; $display("FAIL sub_ovf_value got=%h exp=%h", got, sx(32'h7FFF_FFFF));
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(exp_cnt, 3'b001)) begin
            bad++; $display("FAIL sub_ovf_flag got=%h exp=%h", got, st(exp_cnt, 3'b001));
        end
        bus_write(16'h3F00, 256'd0);
    endtask

    task automatic test_div_zero();
        logic [255:0] got;
        logic [255:0] exp_div;
        logic [255:0] exp_mod;
        logic [255:0] exp_st;
        bus_write(16'h3001, 256'd0);
        exp_cnt = 3;
`ifdef INT_ALU_MULDIV_EN
        exp_div = '1;
        exp_mod = sx(32'h8000_0000);
        exp_st  = st(exp_cnt, 3'b010);
`else
        exp_div = '0;
        exp_mod = '0;
        exp_st  = st(exp_cnt, 3'b100);
`endif
        bus_read(16'h3400, got);
        total++;
        if (got !== exp_div) begin
            bad++; $display("FAIL div_zero got=%h exp=%h", got, exp_div);
        end
        bus_read(16'h3500, got);
        total++;
        if (got !== exp_mod) begin
            bad++; $display("FAIL mod_zero got=%h exp=%h", got, exp_mod);
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== exp_st) begin
            bad++; $display("FAIL dz_status got=%h exp=%h", got, exp_st);
        end
        bus_write(16'h3F00, 256'd0);
    endtask

    task automatic test_illegal();
        logic [255:0] got;
        bus_read(16'h3900, got);
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL reserved_value got=%h exp=%h", got, 256'd0);
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(exp_cnt, 3'b100)) begin
            bad++; $display("FAIL reserved_ill got=%h exp=%h", got, st(exp_cnt, 3'b100));
        end
        bus_write(16'h3F00, 256'd0);
        bus_write(16'h3000, 256'h1234);
        bus_write(16'h3001, 256'd9);
        exp_cnt = 4;
        // Bus conflict on the S2 address: bench drives 0, DUT must neither drive nor write
        @(negedge clk);
        address = 16'h3001; nRead = 1'b0; nWrite = 1'b0; tb_en = 1'b1; tb_data = '0;
        #1 got = dataBus;
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL conflict_drive got=%h exp=%h", got, 256'd0);
        end
        @(posedge clk); #1;
        nRead = 1'b1; nWrite = 1'b1; tb_en = 1'b0; address = 16'h0000;
        bus_read(16'h3001, got);
        total++;
        if (got !== 256'd9) begin
            bad++; $display("FAIL conflict_s2 got=%h exp=%h", got, 256'd9);
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(exp_cnt, 3'b100)) begin
            bad++; $display("FAIL conflict_ill got=%h exp=%h", got, st(exp_cnt, 3'b100));
        end
        bus_write(16'h3F00, 256'd0);
        // Out-of-region read: S1 is nonzero, so a stray drive would disturb the bus
        @(negedge clk);
        address = 16'h4000; nRead = 1'b0; nWrite = 1'b1; tb_en = 1'b1; tb_data = '0;
        #1 got = dataBus;
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL out_region_drive got=%h exp=%h", got, 256'd0);
        end
        @(posedge clk); #1;
        nRead = 1'b1; tb_en = 1'b0; address = 16'h0000;
        bus_write(16'h4001, 256'd5);
        bus_read(16'h3001, got);
        total++;
        if (got !== 256'd9) begin
            bad++; $display("FAIL out_region_write got=%h exp=%h", got, 256'd9);
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(exp_cnt, 3'b000)) begin
            bad++; $display("FAIL out_region_status got=%h exp=%h", got, st(exp_cnt, 3'b000));
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] got;
        bus_write(16'h3000, sx(32'd100));
        bus_write(16'h3001, sx(32'd20));
        exp_cnt = 5;
        bus_read(16'h3200, got);
        total++;
        if (got !== sx(32'd80)) begin
            bad++; $display("FAIL b2b_sub got=%h exp=%h", got, sx(32'd80));
        end
        bus_read(16'h3100, got);
        total++;
        if (got !== sx(32'd120)) begin
            bad++; $display("FAIL b2b_add got=%h exp=%h", got, sx(32'd120));
        end
        bus_read(16'h3D00, got);
        total++;
        if (got !== 256'd1) begin
            bad++; $display("FAIL b2b_gt got=%h exp=%h", got, 256'd1);
        end
    endtask

    task automatic test_wrap();
        logic [255:0] got;
        for (int i = exp_cnt; i < 65535; i++) begin
            bus_write(16'h3001, 256'd1);
        end
        bus_read(16'h3F00, got);
        total++;
        if (got !== st(16'hFFFF, 3'b000)) begin
            bad++; $display("FAIL cnt_max got=%h exp=%h", got, st(16'hFFFF, 3'b000));
        end
        bus_write(16'h3001, 256'd1);
        bus_read(16'h3F00, got);
        total++;
        if (got !== 256'd0) begin
            bad++; $display("FAIL cnt_wrap got=%h exp=%h", got, 256'd0);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        address = 16'h0000;
        nRead   = 1'b1;
        nWrite  = 1'b1;
        tb_en   = 1'b0;
        tb_data = '0;
        test_reset();
        test_arith();
        test_overflow();
        test_div_zero();
        test_illegal();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
